// File: rtl/matmul_job_sequencer.sv
// rtl/matmul_job_sequencer.sv - job-level load/run/drain sequencer for the banked matrix multiplier
//
// Purpose: accepts one job as an element stream (A row-major, then B row-major),
// scatters the elements into the banked A/B BRAMs, holds start_mult until
// mult_done, then drains C row-major as a valid/ready stream.
// Optional feature: define MATMUL_JOB_SEQ_WATCHDOG_EN to enable the RUN watchdog.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   job_start                  job start pulse (honoured in IDLE only)
//   in_valid/in_ready/in_data  element input stream
//   out_valid/out_ready/out_data  C result stream
//   busy, job_done, job_err    status (job_err sticky, watchdog build only)
//   *_a_brams, *_b_brams       A/B bank load ports (Port A of each bank)
//   start_mult, mult_done      multiplier handshake
//   read_en_c, read_addr_c, dout_c  C BRAM read port (1-cycle latency)
module matmul_job_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int M              = 3,
  parameter int K              = 3,
  parameter int N              = 3,
  parameter int N_BANKS        = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW_A  = ((M / N_BANKS) * K > 1) ? $clog2((M / N_BANKS) * K) : 1,
  localparam int AW_B  = ((K * N / N_BANKS) > 1) ? $clog2(K * N / N_BANKS) : 1,
  localparam int AW_C  = ((M * N) > 1) ? $clog2(M * N) : 1,
  localparam int ACC_W = 2 * DATA_WIDTH + ((K > 1) ? $clog2(K) : 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic                          busy,
  output logic                          job_done,
  output logic                          job_err,
  output logic [N_BANKS-1:0]            en_a_brams,
  output logic [N_BANKS-1:0]            we_a_brams,
  output logic [N_BANKS*AW_A-1:0]       addr_a_brams,
  output logic [N_BANKS*DATA_WIDTH-1:0] din_a_brams,
  output logic [N_BANKS-1:0]            en_b_brams,
  output logic [N_BANKS-1:0]            we_b_brams,
  output logic [N_BANKS*AW_B-1:0]       addr_b_brams,
  output logic [N_BANKS*DATA_WIDTH-1:0] din_b_brams,
  output logic                          start_mult,
  input  logic                          mult_done,
  output logic                          read_en_c,
  output logic [AW_C-1:0]               read_addr_c,
  input  logic [ACC_W-1:0]              dout_c
);

  localparam int MAXD = (M > K) ? ((M > N) ? M : N) : ((K > N) ? K : N);
  localparam int DW   = $clog2(MAXD + 1);
  localparam int CW   = $clog2(M * N + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    row_q, row_d, col_q, col_d;
  logic [CW-1:0]    rd_idx_q, rd_idx_d, out_cnt_q, out_cnt_d;
  logic             inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  logic             loading, in_hs, issue, out_hs, last_acc;
  logic [DW-1:0]    row_last, col_last;
  logic [AW_A-1:0]  a_addr;
  logic [AW_B-1:0]  b_addr;

`ifdef MATMUL_JOB_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt_q, run_cnt_d;
  logic          job_err_q, job_err_d;
`endif

  assign loading  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign in_hs    = loading && in_valid;
  assign row_last = (state_q == S_LOAD_A) ? DW'(M - 1) : DW'(K - 1);
  assign col_last = (state_q == S_LOAD_A) ? DW'(K - 1) : DW'(N - 1);
  // One read in flight at most, and only when the output slot will be free
  // by the time the data returns; this caps drain at one element per 2 cycles.
  assign issue    = (state_q == S_DRAIN) && (rd_idx_q < CW'(M * N)) && !inflight_q &&
                    (!out_valid_q || out_ready);
  assign out_hs   = out_valid_q && out_ready;
  assign last_acc = out_hs && (out_cnt_q == CW'(M * N - 1));

  assign a_addr = AW_A'((32'(row_q) / N_BANKS) * K + 32'(col_q));
  assign b_addr = AW_B'(32'(row_q) * (N / N_BANKS) + 32'(col_q) / N_BANKS);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    rd_idx_d    = rd_idx_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = issue;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef MATMUL_JOB_SEQ_WATCHDOG_EN
    run_cnt_d   = run_cnt_q;
    job_err_d   = job_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          state_d   = S_LOAD_A;
          row_d     = '0;
          col_d     = '0;
          rd_idx_d  = '0;
          out_cnt_d = '0;
`ifdef MATMUL_JOB_SEQ_WATCHDOG_EN
          run_cnt_d = '0;
          job_err_d = 1'b0;
`endif
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (in_hs) begin
          if (col_q == col_last) begin
            col_d = '0;
            if (row_q == row_last) begin
              row_d   = '0;
              state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_RUN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_RUN: begin
`ifdef MATMUL_JOB_SEQ_WATCHDOG_EN
        // mult_done wins over a simultaneous timeout
        if (mult_done) begin
          state_d   = S_DRAIN;
          run_cnt_d = '0;
        end else if (run_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          run_cnt_d = '0;
          job_err_d = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
`else
        if (mult_done) state_d = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        if (issue) rd_idx_d = rd_idx_q + 1'b1;
        // A capture never coincides with an output handshake: the read was
        // only issued once the slot was empty or emptying.
        if (inflight_q) begin
          out_data_d  = dout_c;
          out_valid_d = 1'b1;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
        end
        if (out_hs) out_cnt_d = out_cnt_q + 1'b1;
        if (last_acc) begin
          state_d     = S_IDLE;
          rd_idx_d    = '0;
          out_cnt_d   = '0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      rd_idx_q    <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rd_idx_q    <= rd_idx_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MATMUL_JOB_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      job_err_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      job_err_q <= job_err_d;
    end
  end
  assign job_err = job_err_q;
`else
  assign job_err = 1'b0;
`endif

  // Bank write ports: only the target bank is enabled; everything is zero
  // outside the matching load state so the multiplier owns Port A in RUN.
  always_comb begin
    en_a_brams   = '0;
    we_a_brams   = '0;
    addr_a_brams = '0;
    din_a_brams  = '0;
    en_b_brams   = '0;
    we_b_brams   = '0;
    addr_b_brams = '0;
    din_b_brams  = '0;
    if (state_q == S_LOAD_A) begin
      addr_a_brams = {N_BANKS{a_addr}};
      din_a_brams  = {N_BANKS{in_data}};
      for (int b = 0; b < N_BANKS; b++) begin
        en_a_brams[b] = in_hs && ((32'(row_q) % N_BANKS) == 32'(b));
        we_a_brams[b] = in_hs && ((32'(row_q) % N_BANKS) == 32'(b));
      end
    end
    if (state_q == S_LOAD_B) begin
      addr_b_brams = {N_BANKS{b_addr}};
      din_b_brams  = {N_BANKS{in_data}};
      for (int b = 0; b < N_BANKS; b++) begin
        en_b_brams[b] = in_hs && ((32'(col_q) % N_BANKS) == 32'(b));
        we_b_brams[b] = in_hs && ((32'(col_q) % N_BANKS) == 32'(b));
      end
    end
  end

  assign in_ready    = loading;
  assign busy        = (state_q != S_IDLE);
  assign start_mult  = (state_q == S_RUN);
  assign read_en_c   = issue;
  assign read_addr_c = (state_q == S_DRAIN) ? rd_idx_q[AW_C-1:0] : '0;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign job_done    = last_acc;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// tb/tb_matmul_job_sequencer.sv - scoreboard testbench for matmul_job_sequencer
module tb_matmul_job_sequencer;
  localparam int DW = 16, AC = 34, AWA = 2, AWB = 2, AWC = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          job_start = 1'b0, in_valid = 1'b0, out_ready = 1'b1, mult_done = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, busy, job_done, job_err, start_mult, read_en_c;
  logic [AC-1:0] out_data, dout_c;
  logic [2:0]    en_a, we_a, en_b, we_b;
  logic [5:0]    addr_a, addr_b;
  logic [47:0]   din_a, din_b;
  logic [AWC-1:0] read_addr_c;

  matmul_job_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .job_done(job_done), .job_err(job_err),
    .en_a_brams(en_a), .we_a_brams(we_a), .addr_a_brams(addr_a), .din_a_brams(din_a),
    .en_b_brams(en_b), .we_b_brams(we_b), .addr_b_brams(addr_b), .din_b_brams(din_b),
    .start_mult(start_mult), .mult_done(mult_done),
    .read_en_c(read_en_c), .read_addr_c(read_addr_c), .dout_c(dout_c)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // BRAM and multiplier models
  logic [DW-1:0] a_mem [0:2][0:3];
  logic [DW-1:0] b_mem [0:2][0:3];
  logic [AC-1:0] c_mem [0:15];
  logic [AC-1:0] acc;
  logic          mult_hold = 1'b0;
  int            mcnt = 0;

  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (en_a[b] && we_a[b]) a_mem[b][addr_a[b*AWA +: AWA]] <= din_a[b*DW +: DW];
      if (en_b[b] && we_b[b]) b_mem[b][addr_b[b*AWB +: AWB]] <= din_b[b*DW +: DW];
    end
    if (read_en_c) dout_c <= c_mem[read_addr_c];
  end

  always @(posedge clk) begin
    mult_done <= 1'b0;
    if (start_mult && !mult_done && !mult_hold) begin
      mcnt <= mcnt + 1;
      if (mcnt == 3) begin
        for (int r = 0; r < 3; r++)
          for (int n = 0; n < 3; n++) begin
            acc = '0;
            for (int k = 0; k < 3; k++)
              acc = acc + AC'(a_mem[r % 3][(r / 3) * 3 + k]) * AC'(b_mem[n % 3][k + n / 3]);
            c_mem[r * 3 + n] <= acc;
          end
        mult_done <= 1'b1;
        mcnt <= 0;
      end
    end else if (!start_mult) begin
      mcnt <= 0;
    end
  end

  // Scoreboard monitor
  logic [AC-1:0] exp_q [$];
  int            pops = 0, done_total = 0;
  logic          stall_q = 1'b0;
  logic [AC-1:0] held_q = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_q);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("out_data", out_data, exp_q.pop_front());
        pops <= pops + 1;
      end
      if (job_done) done_total <= done_total + 1;
      if (in_valid && in_ready)
        check("one_bank_write", ($countones({en_a, en_b}) == 1) && ({en_a, en_b} == {we_a, we_b}), 1);
      else
        check("no_stray_write", {en_a, we_a, en_b, we_b}, 0);
    end
    stall_q <= out_valid && !out_ready;
    held_q  <= out_data;
  end

  function automatic logic any_out();
    return in_ready | out_valid | busy | job_done | job_err | start_mult | read_en_c |
           (|en_a) | (|we_a) | (|addr_a) | (|din_a) | (|en_b) | (|we_b) | (|addr_b) |
           (|din_b) | (|read_addr_c) | (|out_data);
  endfunction

  logic [DW-1:0] va [9], vb [9];
  logic [AC-1:0] vc [9];

  task automatic load_job(input bit gaps, input bit poke);
    int t;
    @(posedge clk); #1 job_start = 1'b1;
    @(posedge clk); #1 job_start = 1'b0;
    @(negedge clk);
    check("job_err_cleared", job_err, 0);
    check("busy_in_load", busy, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = (i < 9) ? va[i] : vb[i - 9];
      if (poke && i == 12) job_start = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
      job_start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_wait(input bit stall, input bit poke);
    int  start, done0;
    bit  found, stalled, poked;
    for (int i = 0; i < 9; i++) exp_q.push_back(vc[i]);
    start = pops; done0 = done_total; found = 0; stalled = 0; poked = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (job_done) found = 1;
      else if (stall && !stalled && pops - start >= 4) begin
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        stalled = 1;
      end else if (poke && !poked && pops - start >= 2) begin
        @(posedge clk); #1 job_start = 1'b1;
        @(posedge clk); #1 job_start = 1'b0;
        poked = 1;
      end
    end
    if (!found) check("job_done_timeout", found, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("job_done_count", done_total - done0, 1);
    check("all_outputs_seen", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d expected %0d", n_total, 0);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  int cnt;
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", any_out(), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Job 1: A = 1..9, B = identity
    va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    vb = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vc = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_job(0, 0);
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 3; j++)
        check("a_bank_contents", a_mem[b][j], 64'(b * 3 + j + 1));
    drain_wait(0, 0);

    // Job 2: in_valid gaps and an output stall
    load_job(1, 0);
    drain_wait(1, 0);

    // Job 3: B = all ones, job_start pokes in LOAD_B and DRAIN
    vb = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    vc = '{6, 6, 6, 15, 15, 15, 24, 24, 24};
    load_job(0, 1);
    drain_wait(0, 1);

    // Reset in RUN aborts immediately
    mult_hold = 1'b1;
    load_job(0, 0);
    repeat (3) @(negedge clk);
    check("run_start_mult", start_mult, 1);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs", any_out(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    mult_hold = 1'b0;
    vb = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vc = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_job(0, 0);
    drain_wait(0, 0);

`ifdef MATMUL_JOB_SEQ_WATCHDOG_EN
    mult_hold = 1'b1;
    cnt = done_total;
    load_job(0, 0);
    check("wd_done_before", done_total, cnt);
    cnt = 0;
    @(negedge clk);
    while (start_mult && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("wd_run_cycles", cnt, 16);
    check("wd_job_err", job_err, 1);
    check("wd_busy", busy, 0);
    mult_hold = 1'b0;
    cnt = done_total;
    repeat (3) @(negedge clk);
    check("wd_no_done", done_total, cnt);
    load_job(0, 0);
    drain_wait(0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/matmul_job_sequencer.md
# matmul_job_sequencer

Job-level sequencer placed in front of the matrix multiplier `top`. It accepts one job as a valid/ready element stream (all of A, then all of B) and scatters the elements into the banked A/B BRAMs through the shared Port A loading interface. It then holds `start_mult` high until `mult_done` and drains the M×N result from the C BRAM read port as a valid/ready output stream. It is the only master of the multiplier's load, start and read ports.

## Interface
- DATA_WIDTH, 16, element width of A and B.
- M, 3; K, 3; N, 3; dimensions of A (M×K), B (K×N) and C (M×N).
- N_BANKS, 3, BRAM banks per matrix; M and N are multiples of N_BANKS.
- TIMEOUT_CYCLES, 1024, RUN watchdog limit; only used with the watchdog macro.
- Derived: AW_A = clog2(M/N_BANKS*K), AW_B = clog2(K*N/N_BANKS), AW_C = clog2(M*N), each with a minimum of 1; ACC_W = 2*DATA_WIDTH + (K>1 ? clog2(K) : 1).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- job_start  in  1  one-cycle pulse that starts a job; sampled only in IDLE.
- in_valid / in_ready  in/out  1/1  element stream handshake.
- in_data  in  DATA_WIDTH  element.
- out_valid / out_ready  out/in  1/1  result stream handshake.
- out_data  out  ACC_W  C element, row-major.
- busy  out  1  high whenever the FSM is not in IDLE.
- job_done  out  1  one-cycle pulse on acceptance of the last C element.
- job_err  out  1  sticky watchdog error; cleared by `job_start`.
- en_a_brams / we_a_brams  out  N_BANKS each  A bank enables and write enables.
- addr_a_brams  out  N_BANKS*AW_A  A bank addresses.
- din_a_brams  out  N_BANKS*DATA_WIDTH  A bank write data.
- en_b_brams, we_b_brams, addr_b_brams, din_b_brams  out  same shapes with AW_B  B bank signals.
- start_mult  out  1  multiplier start level.
- mult_done  in  1  multiplier completion.
- read_en_c  out  1  C BRAM read enable.
- read_addr_c  out  AW_C  C BRAM read address.
- dout_c  in  ACC_W  C BRAM read data, valid one cycle after `read_en_c`.

## Operation
- The FSM has five states: IDLE, LOAD_A, LOAD_B, RUN, DRAIN.
- IDLE → LOAD_A on `job_start`. On that transition, counters and `job_err` are cleared. `job_start` is ignored outside IDLE.
- LOAD_A: `in_ready` = 1. Each handshake writes element (r,k), counted row-major with r in 0..M-1 and k in 0..K-1.
  - Target bank = r mod N_BANKS; address = (r / N_BANKS)*K + k.
  - After M*K handshakes → LOAD_B.
- LOAD_B: `in_ready` = 1. Each handshake writes element (k,n), counted row-major.
  - Target bank = n mod N_BANKS; address = k*(N/N_BANKS) + n/N_BANKS.
  - After K*N handshakes → RUN.
- Load write port behaviour:
  - On a handshake, only the target bank's `en` and `we` are asserted, combinationally in that cycle.
  - Non-target banks have en = we = 0.
  - din is `in_data` replicated to every lane; addr is the computed address on every lane.
- RUN: `start_mult` = 1 and `in_ready` = 0. When `mult_done` = 1 is sampled: `start_mult` drops in the next cycle and the FSM → DRAIN.
- DRAIN:
  - Read index c runs 0..M*N-1, with `read_addr_c` = c.
  - A read is issued (`read_en_c` = 1) only if no read is in flight and the output register is empty or is handshaking this cycle.
  - `dout_c` is captured into `out_data` one cycle after the read, and `out_valid` is set.
  - On acceptance of element M*N-1: `job_done` pulses and the FSM → IDLE.
- During RUN, all A/B bank outputs are 0. The multiplier's controller owns Port A while `start_mult` is high.

## Timing
- Reset values: every output is 0, including `in_ready`, `out_valid`, `start_mult`, `busy`, `job_done` and `job_err`. The FSM is in IDLE.
- Asserting `rst_n` low mid-job immediately aborts the job and forces all outputs to 0. BRAM contents are not scrubbed.
- Load throughput is 1 element per cycle. Total load is M*K + K*N cycles with no backpressure; `in_valid` gaps stall the counters.
- RUN → DRAIN takes 1 cycle after `mult_done` is sampled.
- Drain throughput is 1 element per 2 cycles maximum. The first `out_valid` appears 2 cycles after DRAIN is entered.
- `out_data` and `out_valid` hold stable while `out_valid` = 1 and `out_ready` = 0. No element is dropped or duplicated.
- Counters wrap to 0 on each state exit.

## Configuration
- `MATMUL_JOB_SEQ_WATCHDOG_EN` defined:
  - A RUN cycle counter runs. If it reaches TIMEOUT_CYCLES without `mult_done`, `start_mult` drops, `job_err` is set (sticky), `job_done` is not pulsed, and the FSM → IDLE.
  - If `mult_done` arrives in the same cycle the limit is reached, it takes priority: the FSM enters DRAIN and no error is raised.
- Not defined: no counter exists, RUN waits indefinitely, and `job_err` is tied to 0.

## Test plan
- Reset, then M=K=N=N_BANKS=3, A = 1..9, B = identity, continuous valid and out_ready = 1 → outputs 1..9 in order; `job_done` pulses once; `busy` is low 1 cycle later.
- Load A = 1..9 → bank 0 address 0..2 gets 1,2,3; bank 1 gets 4,5,6; bank 2 gets 7,8,9. Exactly one `we_a` bit is set per handshake.
- `in_valid` toggled every other cycle and `out_ready` low for 5 cycles mid-drain → results are identical to the first test; `out_data` is held stable while stalled.
- `job_start` pulsed during LOAD_B and DRAIN → ignored; the job completes normally with 9 outputs.
- `rst_n` asserted in RUN → all outputs 0 immediately, FSM in IDLE; a following job produces correct results.
- With the watchdog macro, TIMEOUT_CYCLES=16 and `mult_done` held 0 → `start_mult` falls after 16 RUN cycles, `job_err` = 1, no `job_done`; the next `job_start` clears `job_err`.
